// File: rtl/vload_unit.sv
// vload_unit: byte-serial vector/scalar load sequencer.
// Fetches one (scalar) or LANES (vector) consecutive bytes from a byte-wide,
// 1-cycle-latency memory and issues a single registered write to the
// vector register file write port.
module vload_unit #(
  parameter int AW    = 16,
  parameter int LANES = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 scalar,
  input  logic [AW-1:0]        base_addr,
  input  logic [3:0]           dst,
  output logic                 busy,
  output logic                 err,
  output logic                 mem_re,
  output logic [AW-1:0]        mem_addr,
  input  logic [7:0]           mem_rdata,
  output logic                 WE3,
  output logic                 SFlag,
  output logic                 LDFlag,
  output logic [3:0]           A3,
  output logic [8*LANES-1:0]   WD3,
  output logic                 done
);

  localparam int CW = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    WB
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        n_q, n_d;       // reads issued so far
  logic [CW-1:0]        cap_q, cap_d;   // bytes captured so far
  logic                 re_q;           // mem_rdata valid this cycle
  logic                 scalar_q, scalar_d;
  logic [AW-1:0]        base_q, base_d;
  logic [3:0]           dst_q, dst_d;
  logic [8*LANES-1:0]   buf_q, buf_d;

  logic                 busy_d, err_d, mem_re_d, we_d, sflag_d, ldflag_d, done_d;
  logic [AW-1:0]        mem_addr_d;
  logic [3:0]           a3_d;
  logic [8*LANES-1:0]   wd3_d;
  logic                 illegal;
  logic                 last_issue;

  // Next-state, data-buffer capture and next values of all registered outputs.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    cap_d      = cap_q;
    scalar_d   = scalar_q;
    base_d     = base_q;
    dst_d      = dst_q;
    buf_d      = buf_q;
    busy_d     = 1'b0;
    err_d      = 1'b0;
    mem_re_d   = 1'b0;
    mem_addr_d = mem_addr;
    we_d       = 1'b0;
    sflag_d    = 1'b0;
    ldflag_d   = 1'b0;
    done_d     = 1'b0;
    a3_d       = '0;
    wd3_d      = '0;

    illegal    = scalar ? (dst > 4'(LANES - 1)) : (dst == 4'd15);
    last_issue = scalar_q ? (n_q == CW'(1)) : (n_q == CW'(LANES));

    // Returning byte lands in lane 0 (scalar) or in the lane matching its
    // position in the fetch sequence (vector).
    if (re_q) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if ((scalar_q && i == 0) || (!scalar_q && cap_q == CW'(i))) begin
          buf_d[8*i +: 8] = mem_rdata;
        end
      end
      cap_d = cap_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            scalar_d   = scalar;
            base_d     = base_addr;
            dst_d      = dst;
            buf_d      = '0;
            cap_d      = '0;
            n_d        = CW'(1);
            busy_d     = 1'b1;
            mem_re_d   = 1'b1;
            mem_addr_d = base_addr;
            state_d    = FETCH;
          end
        end
      end
      FETCH: begin
        busy_d = 1'b1;
        if (last_issue) begin
          state_d = DRAIN;
        end else begin
          mem_re_d   = 1'b1;
          mem_addr_d = base_q + AW'(n_q);
          n_d        = n_q + 1'b1;
        end
      end
      DRAIN: begin
        // WD3 is registered on entry to WB, so it takes the buffer with the
        // final byte merged in this cycle.
        busy_d   = 1'b1;
        we_d     = 1'b1;
        done_d   = 1'b1;
        ldflag_d = 1'b1;
        sflag_d  = scalar_q;
        a3_d     = dst_q;
        wd3_d    = scalar_q ? {{(8*LANES-8){1'b0}}, buf_d[7:0]} : buf_d;
        state_d  = WB;
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, sequencing registers and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      cap_q    <= '0;
      re_q     <= 1'b0;
      scalar_q <= 1'b0;
      base_q   <= '0;
      dst_q    <= '0;
      buf_q    <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      mem_re   <= 1'b0;
      mem_addr <= '0;
      WE3      <= 1'b0;
      SFlag    <= 1'b0;
      LDFlag   <= 1'b0;
      A3       <= '0;
      WD3      <= '0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cap_q    <= cap_d;
      re_q     <= mem_re;
      scalar_q <= scalar_d;
      base_q   <= base_d;
      dst_q    <= dst_d;
      buf_q    <= buf_d;
      busy     <= busy_d;
      err      <= err_d;
      mem_re   <= mem_re_d;
      mem_addr <= mem_addr_d;
      WE3      <= we_d;
      SFlag    <= sflag_d;
      LDFlag   <= ldflag_d;
      A3       <= a3_d;
      WD3      <= wd3_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_vload_unit.sv
// Testbench for vload_unit: directed and randomized loads against a
// cycle-indexed reference model of the load protocol.
module tb_vload_unit;

  logic        clk = 1'b0;
  logic        rst, start, scalar;
  logic [15:0] base_addr;
  logic [3:0]  dst;
  logic        busy, err, mem_re;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        WE3, SFlag, LDFlag, done;
  logic [3:0]  A3;
  logic [47:0] WD3;

  int n_vec = 0;
  int n_bad = 0;

  vload_unit #(.AW(16), .LANES(6)) dut (
    .clk(clk), .rst(rst), .start(start), .scalar(scalar),
    .base_addr(base_addr), .dst(dst), .busy(busy), .err(err),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .WE3(WE3), .SFlag(SFlag), .LDFlag(LDFlag), .A3(A3), .WD3(WD3),
    .done(done)
  );

  always #5 clk = ~clk;

  // Data memory: 1-cycle read latency, garbage on the bus when not reading.
  logic [7:0] mem [0:65535];
  always @(posedge clk) mem_rdata <= mem_re ? mem[mem_addr] : 8'($urandom);

  typedef struct packed {
    logic        busy;
    logic        err;
    logic        re;
    logic [15:0] addr;
    logic        we;
    logic        sf;
    logic        lf;
    logic        done;
    logic [3:0]  a3;
    logic [47:0] wd;
  } snap_t;

  snap_t       snap     [0:31];
  logic [15:0] raw_addr [0:31];

  // Expected outputs k cycles after the edge that accepted a single request.
  function automatic snap_t model_at(input logic sc, input logic [15:0] base,
                                     input logic [3:0] d, input int k);
    snap_t e;
    int    nrd, wb;
    e = '0;
    if (sc ? (d > 4'd5) : (d == 4'd15)) begin
      e.err = (k == 1);
      return e;
    end
    nrd    = sc ? 1 : 6;
    wb     = nrd + 2;
    e.busy = (k >= 1 && k <= wb);
    e.re   = (k >= 1 && k <= nrd);
    if (e.re) e.addr = base + 16'(k - 1);
    if (k == wb) begin
      e.we   = 1'b1;
      e.done = 1'b1;
      e.lf   = 1'b1;
      e.sf   = sc;
      e.a3   = d;
      if (sc) e.wd[7:0] = mem[base];
      else for (int i = 0; i < 6; i++) e.wd[8*i +: 8] = mem[16'(base + 16'(i))];
    end
    return e;
  endfunction

  // Issue a request and record outputs for ncyc cycles; optional extra
  // start pulse, reset pulse and restart at given cycle offsets.
  task automatic run_load(input logic sc, input logic [15:0] base, input logic [3:0] d,
                          input int ncyc, input int hold, input int pulse_k,
                          input int rst_k, input int restart_k,
                          input logic [15:0] base2, input logic [3:0] d2);
    snap_t s;
    start = 1'b1; scalar = sc; base_addr = base; dst = d;
    @(posedge clk); #1;
    if (hold == 0) start = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      s.busy = busy; s.err = err; s.re = mem_re;
      s.addr = mem_re ? mem_addr : 16'h0;
      s.we = WE3; s.sf = SFlag; s.lf = LDFlag; s.done = done;
      s.a3 = A3; s.wd = WD3;
      snap[k] = s;
      raw_addr[k] = mem_addr;
      if (k == pulse_k) begin start = 1'b1; scalar = 1'b0; base_addr = base2; dst = d2; end
      if (k == pulse_k + 1) start = 1'b0;
      if (k == rst_k) rst = 1'b1;
      if (k == rst_k + 1) rst = 1'b0;
      if (k == restart_k) begin start = 1'b1; scalar = 1'b0; base_addr = base2; dst = d2; end
      if (k == restart_k + 1) start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    logic [74:0] obs;
    rst = 1'b1; start = 1'b0; scalar = 1'b0; base_addr = '0; dst = '0;
    repeat (3) @(negedge clk);
    obs = {busy, err, mem_re, mem_addr, WE3, SFlag, LDFlag, done, A3, WD3};
    n_vec++;
    if (obs !== '0) begin
      n_bad++; $display("FAIL reset_hold got %h expected 0", obs);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    obs = {busy, err, mem_re, mem_addr, WE3, SFlag, LDFlag, done, A3, WD3};
    n_vec++;
    if (obs !== '0) begin
      n_bad++; $display("FAIL reset_idle got %h expected 0", obs);
    end
  endtask

  task automatic test_vector;
    snap_t e;
    for (int i = 0; i < 6; i++) mem[16'h0010 + i] = 8'(8'h11 * (i + 1));
    run_load(1'b0, 16'h0010, 4'd7, 11, 0, -10, -10, -10, 16'h0, 4'd0);
    for (int k = 1; k <= 11; k++) begin
      e = model_at(1'b0, 16'h0010, 4'd7, k);
      n_vec++;
      if (snap[k] !== e) begin
        n_bad++; $display("FAIL vector k=%0d got %h expected %h", k, snap[k], e);
      end
    end
    n_vec++;
    if (snap[8].wd !== 48'h665544332211 || snap[8].we !== 1'b1 ||
        snap[8].a3 !== 4'd7 || snap[8].sf !== 1'b0) begin
      n_bad++; $display("FAIL vector_wb we=%b a3=%0d sf=%b wd=%h expected 1 7 0 665544332211",
                        snap[8].we, snap[8].a3, snap[8].sf, snap[8].wd);
    end
  endtask

  task automatic test_scalar;
    snap_t e;
    int    nre;
    mem[16'h0200] = 8'hA5;
    run_load(1'b1, 16'h0200, 4'd3, 6, 0, -10, -10, -10, 16'h0, 4'd0);
    nre = 0;
    for (int k = 1; k <= 6; k++) begin
      e = model_at(1'b1, 16'h0200, 4'd3, k);
      if (snap[k].re) nre++;
      n_vec++;
      if (snap[k] !== e) begin
        n_bad++; $display("FAIL scalar k=%0d got %h expected %h", k, snap[k], e);
      end
    end
    n_vec++;
    if (nre !== 1 || snap[3].wd !== 48'h0000000000A5 || snap[3].sf !== 1'b1 ||
        snap[3].lf !== 1'b1 || snap[3].a3 !== 4'd3) begin
      n_bad++; $display("FAIL scalar_wb reads=%0d wd=%h sf=%b lf=%b a3=%0d expected 1 a5 1 1 3",
                        nre, snap[3].wd, snap[3].sf, snap[3].lf, snap[3].a3);
    end
  endtask

  task automatic test_wrap;
    snap_t       e;
    logic [15:0] wa [0:5];
    wa = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003};
    run_load(1'b0, 16'hFFFE, 4'd14, 10, 0, -10, -10, -10, 16'h0, 4'd0);
    for (int k = 1; k <= 10; k++) begin
      e = model_at(1'b0, 16'hFFFE, 4'd14, k);
      n_vec++;
      if (snap[k] !== e) begin
        n_bad++; $display("FAIL wrap k=%0d got %h expected %h", k, snap[k], e);
      end
    end
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (snap[i+1].re !== 1'b1 || snap[i+1].addr !== wa[i]) begin
        n_bad++; $display("FAIL wrap_addr i=%0d got %h expected %h", i, snap[i+1].addr, wa[i]);
      end
    end
  endtask

  task automatic test_illegal;
    snap_t e;
    run_load(1'b1, 16'h0100, 4'd6, 4, 0, -10, -10, -10, 16'h0, 4'd0);
    for (int k = 1; k <= 4; k++) begin
      e = model_at(1'b1, 16'h0100, 4'd6, k);
      n_vec++;
      if (snap[k] !== e) begin
        n_bad++; $display("FAIL illegal_scalar k=%0d got %h expected %h", k, snap[k], e);
      end
    end
    run_load(1'b0, 16'h0100, 4'd15, 4, 0, -10, -10, -10, 16'h0, 4'd0);
    for (int k = 1; k <= 4; k++) begin
      e = model_at(1'b0, 16'h0100, 4'd15, k);
      n_vec++;
      if (snap[k] !== e) begin
        n_bad++; $display("FAIL illegal_vector k=%0d got %h expected %h", k, snap[k], e);
      end
    end
  endtask

  task automatic test_busy_ignore;
    snap_t e;
    run_load(1'b0, 16'h0300, 4'd4, 12, 0, 3, -10, -10, 16'h0500, 4'd9);
    for (int k = 1; k <= 12; k++) begin
      e = model_at(1'b0, 16'h0300, 4'd4, k);
      n_vec++;
      if (snap[k] !== e) begin
        n_bad++; $display("FAIL busy_ignore k=%0d got %h expected %h", k, snap[k], e);
      end
    end
  endtask

  task automatic test_reset_midload;
    snap_t e;
    run_load(1'b0, 16'h0400, 4'd2, 17, 0, -10, 4, 6, 16'h0600, 4'd11);
    for (int k = 1; k <= 17; k++) begin
      if (k <= 4)      e = model_at(1'b0, 16'h0400, 4'd2, k);
      else if (k <= 6) e = '0;
      else             e = model_at(1'b0, 16'h0600, 4'd11, k - 6);
      n_vec++;
      if (snap[k] !== e) begin
        n_bad++; $display("FAIL reset_midload k=%0d got %h expected %h", k, snap[k], e);
      end
    end
    n_vec++;
    if (raw_addr[5] !== 16'h0) begin
      n_bad++; $display("FAIL reset_midload_addr got %h expected 0", raw_addr[5]);
    end
  endtask

  task automatic test_back_to_back;
    snap_t e;
    int    idle_seen;
    run_load(1'b0, 16'h0700, 4'd12, 20, 1, -10, -10, -10, 16'h0, 4'd0);
    for (int k = 1; k <= 20; k++) begin
      e = model_at(1'b0, 16'h0700, 4'd12, ((k - 1) % 9) + 1);
      n_vec++;
      if (snap[k] !== e) begin
        n_bad++; $display("FAIL back_to_back k=%0d got %h expected %h", k, snap[k], e);
      end
    end
    idle_seen = 0;
    for (int c = 0; c < 20 && idle_seen == 0; c++) begin
      @(negedge clk);
      if (!busy) idle_seen = 1;
    end
    n_vec++;
    if (idle_seen != 1) begin
      n_bad++; $display("FAIL back_to_back_drain busy stuck got 1 expected 0");
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    snap_t       e;
    logic        sc;
    logic [3:0]  d;
    logic [15:0] base;
    int          ncyc;
    for (int it = 0; it < 30; it++) begin
      sc   = 1'($urandom_range(0, 1));
      d    = 4'($urandom_range(0, 15));
      base = 16'($urandom);
      for (int i = 0; i < 6; i++) mem[16'(base + 16'(i))] = 8'($urandom);
      if (sc ? (d > 4'd5) : (d == 4'd15)) ncyc = 3;
      else ncyc = sc ? 5 : 10;
      run_load(sc, base, d, ncyc, 0, -10, -10, -10, 16'h0, 4'd0);
      for (int k = 1; k <= ncyc; k++) begin
        e = model_at(sc, base, d, k);
        n_vec++;
        if (snap[k] !== e) begin
          n_bad++; $display("FAIL random it=%0d sc=%b dst=%0d base=%h k=%0d got %h expected %h",
                            it, sc, d, base, k, snap[k], e);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset;
    test_vector;
    test_scalar;
    test_wrap;
    test_illegal;
    test_busy_ignore;
    test_reset_midload;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vload_unit.md
# vload_unit

Multi-cycle vector/scalar load sequencer feeding the vector register file write port. On a start request it reads one or six consecutive bytes from a byte-wide, 1-cycle-latency data memory, assembles them into a 6-lane × 8-bit vector, and issues a single registered write (WE3/A3/WD3 with SFlag/LDFlag) to the register file. It sits between the memory stage and the register file, replacing single-cycle vector loads with a byte-serial fetch.

## Interface
- AW, 16, data-memory byte address width
- LANES, 6, vector lanes (fixed by register file format; not to be changed)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  load request; sampled only when busy=0
- scalar  in  1  1 = scalar load (one byte), 0 = vector load (six bytes); sampled with start
- base_addr  in  AW  byte address of lane 0; sampled with start
- dst  in  4  vector: destination register 0..14; scalar: scalar lane 0..5; sampled with start
- busy  out  1  high from cycle after accepted start through the WB cycle
- err  out  1  one-cycle pulse: request rejected (illegal dst)
- mem_re  out  1  memory read enable
- mem_addr  out  AW  memory read address
- mem_rdata  in  8  read data, valid exactly one cycle after mem_re
- WE3  out  1  register file write enable (one-cycle pulse)
- SFlag  out  1  scalar write flag, valid with WE3
- LDFlag  out  1  load flag, valid with WE3
- A3  out  4  destination index, valid with WE3
- WD3  out  48  write data; lane i = bits [8i+7:8i]
- done  out  1  one-cycle pulse, coincident with WE3

## Operation
- States: IDLE, FETCH, DRAIN, WB. All outputs registered.
- IDLE: busy=0. On start=1: if (scalar=1 and dst>5) or (scalar=0 and dst=15) -> err=1 next cycle, stay IDLE. Otherwise latch scalar/base_addr/dst, clear data buffer, issue counter n=0, go FETCH.
- FETCH: mem_re=1, mem_addr=base_addr+n (mod 2^AW, wraps), n increments each cycle. Issues 6 reads (vector) or 1 read (scalar); after the last issue go DRAIN.
- Capture: a registered copy of mem_re marks valid mem_rdata; byte from base_addr+i written to lane i of the buffer (scalar: lane 0).
- DRAIN: mem_re=0; captures final byte; go WB.
- WB: WE3=1, done=1, LDFlag=1, A3=latched dst; vector: SFlag=0, WD3=buffer; scalar: SFlag=1, WD3[7:0]=byte, lanes 1..5 = 0. Next state IDLE.
- start while busy=1 is ignored (no queuing, no err).
- Vector dst=0 is legal (overwrites all six scalar lanes).

## Timing
- Reset: state IDLE; busy, err, mem_re, WE3, SFlag, LDFlag, done = 0; mem_addr, A3, WD3 = 0; buffer cleared.
- Start accepted at edge T (state IDLE, start=1). Vector: FETCH T+1..T+6 (addresses base..base+5), DRAIN T+7, WB T+8, next start accepted at T+9. Scalar: FETCH T+1, DRAIN T+2, WB T+3, next start at T+4.
- busy high T+1 through the WB cycle inclusive; low in the cycle after WB.
- err asserted at T+1 for exactly one cycle; busy stays 0.
- Outside WB: WE3, done, SFlag, LDFlag = 0; A3, WD3 hold 0.
- rst during any state: next cycle IDLE with reset values; no WE3 for the interrupted load; a mem_rdata arriving after reset is discarded.
- Back-to-back: start held high continuously yields one load per 9 cycles (vector).

## Test plan
- Vector load, base=0x0010, memory[0x10..0x15]=11,22,33,44,55,66, dst=7 -> WE3 at T+8, SFlag=0, A3=7, WD3=0x665544332211; mem_addr 0x10..0x15 on T+1..T+6.
- Scalar load, base=0x0200, memory[0x200]=0xA5, dst=3 -> WE3 at T+3, SFlag=1, LDFlag=1, A3=3, WD3=0x0000000000A5; exactly one mem_re.
- Wrap: vector base=0xFFFE -> mem_addr FFFE,FFFF,0000,0001,0002,0003; lanes filled in that order.
- Illegal: scalar dst=6 and vector dst=15 -> err pulse at T+1, no mem_re, no WE3, busy=0.
- Start pulsed at T+3 during a vector load -> ignored; single WE3 at T+8 with original dst/data.
- rst at T+4 of a vector load -> all outputs 0 at T+5, no WE3 ever; new start at T+6 completes normally at T+14.
